riscv_dcache_data_nway: RTL and testbench
=========================================

// Module: riscv_dcache_data_nway
// PURPOSE
// - Set-associative D-cache data array: WAYS ways x SETS lines x LINE_BYTES bytes.
// - Byte/half/word/double stores are merged into the addressed line.
// - Line refill arrives from the memory interface in FILL_WIDTH beats, with a valid/ready handshake.
// - Reads are registered, with 1-cycle latency. Sits between the D-cache controller (tag/hit logic) and the memory port.
// PARAMETERS
// - WAYS        4    number of ways, power of 2, >=1
// - SETS        256  lines per way, power of 2
// - LINE_BYTES  16   bytes per line, power of 2, >=8
// - FILL_WIDTH  64   refill beat width in bits; divides LINE_BYTES*8
// - Derived: LW=LINE_BYTES*8, IW=$clog2(SETS), OW=$clog2(LINE_BYTES), WW=max(1,$clog2(WAYS)), BEATS=LW/FILL_WIDTH
// PORTS
// - clk          in   1           clock, all state updates on rising edge
// - rst          in   1           synchronous, active-high reset
// - rden         in   1           read request: way_sel/index
// - wren         in   1           store request: way_sel/index/byte_offset
// - way_sel      in   WW          way for read/store
// - index        in   IW          set index for read/store
// - byte_offset  in   OW          byte offset inside line
// - storesrc     in   2           00 byte, 01 half, 10 word, 11 double
// - store_data   in   64          store data, right-aligned
// - fill_start   in   1           begin refill of fill_way/fill_index
// - fill_way     in   WW          refill target way, sampled at fill_start
// - fill_index   in   IW          refill target set, sampled at fill_start
// - fill_valid   in   1           refill beat valid
// - fill_data    in   FILL_WIDTH  refill beat, beat 0 = line LSBs
// - fill_ready   out  1           array accepts beat
// - fill_done    out  1           1-cycle pulse after last beat written
// - busy         out  1           refill in progress; rden/wren ignored
// - rd_valid     out  1           data_out valid, 1 cycle after accepted rden
// - data_out     out  LW          registered line read
// BEHAVIOUR
// - Reset values: fill_ready=0, fill_done=0, busy=0, rd_valid=0, data_out=0, FSM=IDLE, beat counter=0. Array contents are not reset.
// - FSM: IDLE -(fill_start)-> FILL -(last beat accepted)-> DONE -> IDLE.
//   - busy=1 in FILL and DONE.
//   - fill_ready=1 only in FILL.
//   - fill_done=1 only in DONE.
// - FILL: on fill_valid&&fill_ready, write beat cnt to line[cnt*FILL_WIDTH +: FILL_WIDTH] and increment cnt. cnt==BEATS-1 accepted -> DONE, cnt<=0.
// - fill_valid low in FILL: stall, no write, cnt holds. No timeout.
// - IDLE access priority: fill_start > rden > wren.
//   - fill_start drops a same-cycle rden/wren (rd_valid stays 0).
//   - rden&&wren: the read is performed and the store is suppressed.
// - Store (IDLE, wren, !rden): size=1<<storesrc bytes. Offset low log2(size) bits are ignored, so the store is aligned down.
//   - Write store_data[size*8-1:0] to bytes [off .. off+size-1] of way_sel/index. Other bytes and ways are unchanged.
// - Read (IDLE, rden): data_out<=array[way_sel][index], rd_valid<=1 next cycle. Otherwise rd_valid<=0 and data_out holds.
// - Read of a line stored in the previous cycle returns the new data. There is no same-cycle bypass.
// - fill_start while busy: ignored.
// - rst mid-refill: FSM to IDLE immediately. Partially written line is left as-is (tag side must not mark it valid).
// - WAYS=1: way_sel and fill_way are ignored.
// CONFIGURATION
// - DCACHE_PARITY_EN defined:
//   - One even-parity bit per byte is stored alongside the data and updated on every store and fill write.
//   - Added output parity_err (1 bit): registered with data_out, =1 if any byte of the read line mismatches. Reset 0.
// - DCACHE_PARITY_EN undefined: no parity storage, no parity_err port.
// TESTING
// - Refill WAYS=4, way2/index5, 2 beats 64'h1111..,64'h2222.. with fill_valid gap -> fill_done 1 cycle after beat 1; read way2/idx5 -> data_out={2222..,1111..}.
// - Byte store 8'hAB at offset 9 into line of zeros, then read -> only bits[79:72]=AB, rd_valid 1 cycle after rden.
// - Word store 32'hDEADBEEF with offset 6 (aligned to 4) -> bits[63:32]=DEADBEEF; way1 same index unchanged.
// - rden&&wren same cycle, then read -> the read returns the old line and the store is not applied.
// - rst asserted after beat 0 of 2 -> busy=0, fill_ready=0 next cycle; new fill_start accepted immediately.
// - DCACHE_PARITY_EN: force a flipped bit in the array, then read -> parity_err=1 with rd_valid; clean line -> parity_err=0.

Source files
------------

// File: rtl/riscv_dcache_data_nway_if.sv
// Request/refill/read-data bundle between the D-cache controller and its data array.
// Optional DCACHE_PARITY_EN adds the parity_err read-side flag.
interface riscv_dcache_data_nway_if #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 256,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned FILL_WIDTH = 64
);
  localparam int unsigned LW = LINE_BYTES * 8;
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned OW = $clog2(LINE_BYTES);
  localparam int unsigned WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic                  rden;
  logic                  wren;
  logic [WW-1:0]         way_sel;
  logic [IW-1:0]         index;
  logic [OW-1:0]         byte_offset;
  logic [1:0]            storesrc;
  logic [63:0]           store_data;
  logic                  fill_start;
  logic [WW-1:0]         fill_way;
  logic [IW-1:0]         fill_index;
  logic                  fill_valid;
  logic [FILL_WIDTH-1:0] fill_data;
  logic                  fill_ready;
  logic                  fill_done;
  logic                  busy;
  logic                  rd_valid;
  logic [LW-1:0]         data_out;
`ifdef DCACHE_PARITY_EN
  logic                  parity_err;
`endif

  modport master (
    output rden, wren, way_sel, index, byte_offset, storesrc, store_data,
    output fill_start, fill_way, fill_index, fill_valid, fill_data,
    input  fill_ready, fill_done, busy, rd_valid, data_out
`ifdef DCACHE_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  rden, wren, way_sel, index, byte_offset, storesrc, store_data,
    input  fill_start, fill_way, fill_index, fill_valid, fill_data,
    output fill_ready, fill_done, busy, rd_valid, data_out
`ifdef DCACHE_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/riscv_dcache_data_nway.sv
// Set-associative D-cache data array: merged byte/half/word/double stores, beat-wise refill, registered reads.
// Define DCACHE_PARITY_EN to store a per-byte even-parity bit and flag mismatches on read (parity_err).
module riscv_dcache_data_nway #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 256,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned FILL_WIDTH = 64
) (
  input logic clk,
  input logic rst,
  riscv_dcache_data_nway_if.slave bus
);
  localparam int unsigned LW    = LINE_BYTES * 8;
  localparam int unsigned IW    = $clog2(SETS);
  localparam int unsigned OW    = $clog2(LINE_BYTES);
  localparam int unsigned WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned BEATS = LW / FILL_WIDTH;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef DCACHE_PARITY_EN
  localparam int unsigned FB    = FILL_WIDTH / 8;
`endif

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WW-1:0]   fway;
  logic [IW-1:0]   fidx;
  logic [WW-1:0]   rw;
  logic [WW-1:0]   fw_in;
  logic            take_fill, fill_acc, fill_last, do_rd, do_st;
  logic [OW-1:0]   st_off;
  logic [LINE_BYTES-1:0] st_be;
  logic [LW-1:0]   st_line;

  logic [LW-1:0] mem [WAYS][SETS];
`ifdef DCACHE_PARITY_EN
  logic [LINE_BYTES-1:0] par [WAYS][SETS];
  logic [LW-1:0]         rd_line;
  logic [LINE_BYTES-1:0] rd_par_calc;
`endif

  assign rw    = (WAYS == 1) ? '0 : bus.way_sel;
  assign fw_in = (WAYS == 1) ? '0 : bus.fill_way;

  always_comb begin
    state_nxt = state;
    take_fill = 1'b0;
    fill_acc  = 1'b0;
    fill_last = 1'b0;
    do_rd     = 1'b0;
    do_st     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.fill_start) begin
          take_fill = 1'b1;
          state_nxt = FILL;
        end else if (bus.rden) begin
          do_rd = 1'b1;
        end else if (bus.wren) begin
          do_st = 1'b1;
        end
      end
      FILL: begin
        if (bus.fill_valid) begin
          fill_acc  = 1'b1;
          fill_last = (cnt == CW'(BEATS - 1));
          if (fill_last) state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    bus.fill_ready = (state == FILL);
    bus.fill_done  = (state == DONE);
    bus.busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (take_fill) begin
        fway <= fw_in;
        fidx <= bus.fill_index;
        cnt  <= '0;
      end
      if (fill_acc) cnt <= fill_last ? '0 : cnt + 1'b1;
    end
  end

  // Store alignment: clear the low log2(size) offset bits, then place the right-aligned data there.
  always_comb begin
    st_off  = bus.byte_offset & ~OW'((4'd1 << bus.storesrc) - 4'd1);
    st_line = LW'(bus.store_data) << {st_off, 3'b000};
    for (int unsigned b = 0; b < LINE_BYTES; b++)
      st_be[b] = (b >= 32'(st_off)) && (b < 32'(st_off) + (32'd1 << bus.storesrc));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_st) begin
        for (int unsigned b = 0; b < LINE_BYTES; b++) begin
          if (st_be[b]) begin
            mem[rw][bus.index][b*8 +: 8] <= st_line[b*8 +: 8];
`ifdef DCACHE_PARITY_EN
            par[rw][bus.index][b] <= ^st_line[b*8 +: 8];
`endif
          end
        end
      end
      if (fill_acc) begin
        mem[fway][fidx][cnt*FILL_WIDTH +: FILL_WIDTH] <= bus.fill_data;
`ifdef DCACHE_PARITY_EN
        for (int unsigned k = 0; k < FB; k++)
          par[fway][fidx][cnt*FB + k] <= ^bus.fill_data[k*8 +: 8];
`endif
      end
    end
  end

`ifdef DCACHE_PARITY_EN
  always_comb begin
    rd_line = mem[rw][bus.index];
    for (int unsigned b = 0; b < LINE_BYTES; b++)
      rd_par_calc[b] = ^rd_line[b*8 +: 8];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_valid   <= 1'b0;
      bus.data_out   <= '0;
`ifdef DCACHE_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
    end else begin
      bus.rd_valid <= do_rd;
      if (do_rd) begin
        bus.data_out   <= mem[rw][bus.index];
`ifdef DCACHE_PARITY_EN
        bus.parity_err <= |(rd_par_calc ^ par[rw][bus.index]);
`endif
      end
    end
  end
endmodule

// File: tb/tb_riscv_dcache_data_nway.sv
// Scoreboard bench for riscv_dcache_data_nway: expected lines queued at read issue, compared on rd_valid.
module tb_riscv_dcache_data_nway;
  localparam int unsigned WAYS = 4, SETS = 256, LINE_BYTES = 16, FILL_WIDTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_dcache_data_nway_if #(.WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES), .FILL_WIDTH(FILL_WIDTH)) bus ();

  riscv_dcache_data_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES), .FILL_WIDTH(FILL_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] model [int];
  logic [127:0] expq [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] apply_store(input logic [127:0] line, input int off,
                                              input int src, input logic [63:0] data);
    int size = 1 << src;
    int base = off - (off % size);
    for (int k = 0; k < size; k++) line[(base + k)*8 +: 8] = data[k*8 +: 8];
    return line;
  endfunction

  task automatic do_fill(input int w, input int i, input logic [63:0] b0, input logic [63:0] b1, input int gap);
    bus.fill_start = 1'b1;
    bus.fill_way   = w[1:0];
    bus.fill_index = i[7:0];
    cyc();
    bus.fill_start = 1'b0;
    check("fill_ready_on", bus.fill_ready, 1);
    check("busy_on", bus.busy, 1);
    for (int b = 0; b < 2; b++) begin
      repeat (gap) begin
        bus.fill_valid = 1'b0;
        cyc();
        check("stall_no_done", bus.fill_done, 0);
      end
      bus.fill_valid = 1'b1;
      bus.fill_data  = (b == 0) ? b0 : b1;
      cyc();
    end
    bus.fill_valid = 1'b0;
    check("fill_done_pulse", bus.fill_done, 1);
    check("fill_ready_off", bus.fill_ready, 0);
    check("busy_done", bus.busy, 1);
    cyc();
    check("fill_done_drop", bus.fill_done, 0);
    check("busy_off", bus.busy, 0);
    model[w*SETS + i] = {b1, b0};
  endtask

  task automatic do_store(input int w, input int i, input int off, input int src, input logic [63:0] d);
    bus.wren        = 1'b1;
    bus.way_sel     = w[1:0];
    bus.index       = i[7:0];
    bus.byte_offset = off[3:0];
    bus.storesrc    = src[1:0];
    bus.store_data  = d;
    cyc();
    bus.wren = 1'b0;
    model[w*SETS + i] = apply_store(model[w*SETS + i], off, src, d);
  endtask

  task automatic do_read(input int w, input int i);
    bus.rden    = 1'b1;
    bus.way_sel = w[1:0];
    bus.index   = i[7:0];
    expq.push_back(model[w*SETS + i]);
    cyc();
    bus.rden = 1'b0;
    check("rd_valid", bus.rd_valid, 1);
    if (expq.size() > 0) check("rd_data", bus.data_out, expq.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    bus.rden = 0; bus.wren = 0; bus.way_sel = 0; bus.index = 0; bus.byte_offset = 0;
    bus.storesrc = 0; bus.store_data = 0; bus.fill_start = 0; bus.fill_way = 0;
    bus.fill_index = 0; bus.fill_valid = 0; bus.fill_data = 0;
    repeat (2) cyc();
    check("rst_fill_ready", bus.fill_ready, 0);
    check("rst_fill_done", bus.fill_done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_data_out", bus.data_out, 0);
    rst = 1'b0;
    cyc();

    do_fill(2, 5, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1);
    do_read(2, 5);
    check("fill_line", bus.data_out, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    do_fill(0, 9, 64'h0, 64'h0, 0);
    do_store(0, 9, 9, 0, 64'h0000_0000_0000_00AB);
    do_read(0, 9);
    check("byte_store", bus.data_out, 128'h000000000000AB000000000000000000);
    cyc();
    check("rd_valid_drop", bus.rd_valid, 0);

    do_fill(3, 7, 64'h0, 64'h0, 0);
    do_fill(1, 7, 64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 2);
    do_store(3, 7, 6, 2, 64'hFFFF_FFFF_DEAD_BEEF);
    do_read(3, 7);
    check("word_store", bus.data_out, 128'h0000000000000000DEADBEEF00000000);
    do_read(1, 7);

    do_store(2, 5, 3, 1, 64'h0000_0000_0000_1234);
    do_store(2, 5, 13, 3, 64'h0123_4567_89AB_CDEF);
    do_read(2, 5);

    // read and store in the same cycle: read wins, store dropped
    bus.rden = 1'b1; bus.wren = 1'b1; bus.way_sel = 2'd0; bus.index = 8'd9;
    bus.byte_offset = 4'd0; bus.storesrc = 2'd3; bus.store_data = '1;
    expq.push_back(model[0*SETS + 9]);
    cyc();
    bus.rden = 1'b0; bus.wren = 1'b0;
    check("rdwr_valid", bus.rd_valid, 1);
    check("rdwr_data", bus.data_out, expq.pop_front());
    do_read(0, 9);

    // fill_start drops a same-cycle read; requests during the refill are ignored
    bus.fill_start = 1'b1; bus.fill_way = 2'd1; bus.fill_index = 8'd20;
    bus.rden = 1'b1; bus.way_sel = 2'd0; bus.index = 8'd9;
    cyc();
    bus.rden = 1'b0;
    check("fs_drops_rd", bus.rd_valid, 0);
    check("fs_busy", bus.busy, 1);
    bus.fill_way = 2'd3; bus.fill_index = 8'd99;
    bus.wren = 1'b1; bus.byte_offset = 4'd0; bus.storesrc = 2'd3; bus.store_data = '1;
    cyc();
    bus.fill_start = 1'b0; bus.wren = 1'b0;
    bus.rden = 1'b1;
    cyc();
    bus.rden = 1'b0;
    check("busy_drops_rd", bus.rd_valid, 0);
    bus.fill_valid = 1'b1; bus.fill_data = 64'hC0C0_C0C0_C0C0_C0C0;
    cyc();
    bus.fill_data = 64'hC1C1_C1C1_C1C1_C1C1;
    cyc();
    bus.fill_valid = 1'b0;
    check("busy_fill_done", bus.fill_done, 1);
    cyc();
    model[1*SETS + 20] = {64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
    do_read(1, 20);
    do_read(0, 9);

    // reset in the middle of a refill
    bus.fill_start = 1'b1; bus.fill_way = 2'd2; bus.fill_index = 8'd30;
    cyc();
    bus.fill_start = 1'b0;
    bus.fill_valid = 1'b1; bus.fill_data = 64'hD0D0_D0D0_D0D0_D0D0;
    cyc();
    bus.fill_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_ready", bus.fill_ready, 0);
    do_fill(2, 30, 64'hE0E0_E0E0_E0E0_E0E0, 64'hE1E1_E1E1_E1E1_E1E1, 0);
    do_read(2, 30);

`ifdef DCACHE_PARITY_EN
    do_read(2, 5);
    check("parity_clean", bus.parity_err, 0);
    dut.mem[2][5][0] = ~dut.mem[2][5][0];
    model[2*SETS + 5][0] = ~model[2*SETS + 5][0];
    do_read(2, 5);
    check("parity_flip", bus.parity_err, 1);
`endif

    check("scoreboard_empty", 128'(expq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
